// File: rtl/i2s_apb_dma_fifo_if.sv
// APB bus bundle between the HPS master and the I2S sample FIFO slave.
interface i2s_apb_dma_fifo_if;
   logic [4:0]  paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/i2s_apb_dma_fifo.sv
// APB slave buffering I2S playback/capture samples in two FIFOs, with
// DMA single/burst requests and a level interrupt.
module i2s_apb_dma_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   i2s_apb_dma_fifo_if.slave    apb,
   output logic [31:0]          pb_data,
   input  logic                 pb_read,
   output logic                 pb_empty,
   input  logic [31:0]          cap_data,
   input  logic                 cap_write,
   output logic                 cap_full,
   output logic                 pb_dma_single,
   output logic                 pb_dma_req,
   input  logic                 pb_dma_ack,
   output logic                 cap_dma_single,
   output logic                 cap_dma_req,
   input  logic                 cap_dma_ack,
   output logic                 irq
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;

   localparam logic [4:0] A_DATA   = 5'h00;
   localparam logic [4:0] A_STATUS = 5'h04;
   localparam logic [4:0] A_CTRL   = 5'h08;
   localparam logic [4:0] A_THRESH = 5'h0C;
   localparam logic [4:0] A_FLAGS  = 5'h10;
   localparam logic [4:0] A_IRQEN  = 5'h14;

   logic [31:0]   pb_mem  [DEPTH];
   logic [31:0]   cap_mem [DEPTH];
   logic [PW-1:0] pb_wptr, pb_rptr, cap_wptr, cap_rptr;
   logic [CW-1:0] pb_cnt, cap_cnt;
   logic          pb_dma_en, cap_dma_en;
   logic [7:0]    pb_wm, cap_wm;
   logic [1:0]    sticky;
   logic [3:0]    irq_en;

   logic access, wr, rd;
   logic pb_full, cap_empty;
   logic pb_pop, pb_push, pb_clr;
   logic cap_pop, cap_push, cap_clr;
   logic pb_low, cap_high;
   logic [1:0]  sticky_set, sticky_w1c;
   logic [3:0]  flags;
   logic [7:0]  pb_free;
   logic [31:0] status;

   // Reset also masks the bus so the slave is silent while held in reset.
   assign access = apb.psel & apb.penable & reset_n;
   assign wr     = access & apb.pwrite;
   assign rd     = access & ~apb.pwrite;
   assign apb.pready = access;

   assign pb_empty  = (pb_cnt == '0);
   assign pb_full   = (pb_cnt == CW'(DEPTH));
   assign cap_empty = (cap_cnt == '0);
   assign cap_full  = (cap_cnt == CW'(DEPTH));

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign pb_pop   = pb_read & ~pb_empty;
   assign pb_push  = wr & (apb.paddr == A_DATA) & (~pb_full | pb_pop);
   assign pb_clr   = wr & (apb.paddr == A_CTRL) & apb.pwdata[0];
   assign cap_pop  = rd & (apb.paddr == A_DATA) & ~cap_empty;
   assign cap_push = cap_write & (~cap_full | cap_pop);
   assign cap_clr  = wr & (apb.paddr == A_CTRL) & apb.pwdata[2];

   assign pb_data = pb_empty ? 32'h0 : pb_mem[pb_rptr];

   assign pb_low     = (8'(pb_cnt) <= pb_wm);
   assign cap_high   = (cap_wm != 8'h0) & (8'(cap_cnt) >= cap_wm);
   assign sticky_set = {cap_write & cap_full & ~cap_pop, pb_read & pb_empty};
   assign sticky_w1c = (wr & (apb.paddr == A_FLAGS)) ? apb.pwdata[1:0] : 2'b00;
   assign flags      = {cap_high, pb_low, sticky};
   assign irq        = |(flags & irq_en);

   assign pb_free = 8'(CW'(DEPTH) - pb_cnt);

   assign status = {8'(cap_cnt), 8'h00, 8'(pb_cnt), 2'b00,
                    cap_dma_en, cap_full, cap_empty, pb_dma_en, pb_full, pb_empty};

   // Playback FIFO storage.
   always_ff @(posedge clk) begin
      if (pb_push & ~pb_clr)
         pb_mem[pb_wptr] <= apb.pwdata;
   end

   // Capture FIFO storage.
   always_ff @(posedge clk) begin
      if (cap_push & ~cap_clr)
         cap_mem[cap_wptr] <= cap_data;
   end

   // Playback pointers and occupancy; clear overrides push and pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pb_wptr <= '0;
         pb_rptr <= '0;
         pb_cnt  <= '0;
      end else if (pb_clr) begin
         pb_wptr <= '0;
         pb_rptr <= '0;
         pb_cnt  <= '0;
      end else begin
         if (pb_push)
            pb_wptr <= pb_wptr + PW'(1);
         if (pb_pop)
            pb_rptr <= pb_rptr + PW'(1);
         if (pb_push & ~pb_pop)
            pb_cnt <= pb_cnt + CW'(1);
         else if (pb_pop & ~pb_push)
            pb_cnt <= pb_cnt - CW'(1);
      end
   end

   // Capture pointers and occupancy; clear overrides push and pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_wptr <= '0;
         cap_rptr <= '0;
         cap_cnt  <= '0;
      end else if (cap_clr) begin
         cap_wptr <= '0;
         cap_rptr <= '0;
         cap_cnt  <= '0;
      end else begin
         if (cap_push)
            cap_wptr <= cap_wptr + PW'(1);
         if (cap_pop)
            cap_rptr <= cap_rptr + PW'(1);
         if (cap_push & ~cap_pop)
            cap_cnt <= cap_cnt + CW'(1);
         else if (cap_pop & ~cap_push)
            cap_cnt <= cap_cnt - CW'(1);
      end
   end

   // Control, threshold, interrupt registers; a new sticky event beats W1C.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pb_dma_en  <= 1'b0;
         cap_dma_en <= 1'b0;
         pb_wm      <= 8'(DEPTH / 2);
         cap_wm     <= 8'(DEPTH / 2);
         irq_en     <= 4'h0;
         sticky     <= 2'b00;
      end else begin
         if (wr & (apb.paddr == A_CTRL)) begin
            pb_dma_en  <= apb.pwdata[1];
            cap_dma_en <= apb.pwdata[3];
         end
         if (wr & (apb.paddr == A_THRESH)) begin
            pb_wm  <= apb.pwdata[7:0];
            cap_wm <= apb.pwdata[23:16];
         end
         if (wr & (apb.paddr == A_IRQEN))
            irq_en <= apb.pwdata[3:0];
         sticky <= (sticky & ~sticky_w1c) | sticky_set;
      end
   end

   // DMA requests follow FIFO state by one edge; an ack squashes them for one edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pb_dma_single  <= 1'b0;
         pb_dma_req     <= 1'b0;
         cap_dma_single <= 1'b0;
         cap_dma_req    <= 1'b0;
      end else begin
         if (pb_dma_ack) begin
            pb_dma_single <= 1'b0;
            pb_dma_req    <= 1'b0;
         end else begin
            pb_dma_single <= pb_dma_en & ~pb_full;
            pb_dma_req    <= pb_dma_en & (pb_wm != 8'h0) & (pb_free >= pb_wm);
         end
         if (cap_dma_ack) begin
            cap_dma_single <= 1'b0;
            cap_dma_req    <= 1'b0;
         end else begin
            cap_dma_single <= cap_dma_en & ~cap_empty;
            cap_dma_req    <= cap_dma_en & cap_high;
         end
      end
   end

   // Read data and error response, live only during the access phase.
   always_comb begin
      apb.prdata  = 32'h0;
      apb.pslverr = 1'b0;
      if (access) begin
         case (apb.paddr)
            A_DATA: begin
               if (apb.pwrite)
                  apb.pslverr = pb_full & ~pb_read;
               else if (cap_empty)
                  apb.pslverr = 1'b1;
               else
                  apb.prdata = cap_mem[cap_rptr];
            end
            A_STATUS: if (!apb.pwrite) apb.prdata = status;
            A_CTRL:   if (!apb.pwrite) apb.prdata = {28'h0, cap_dma_en, 1'b0, pb_dma_en, 1'b0};
            A_THRESH: if (!apb.pwrite) apb.prdata = {8'h0, cap_wm, 8'h0, pb_wm};
            A_FLAGS:  if (!apb.pwrite) apb.prdata = {28'h0, flags};
            A_IRQEN:  if (!apb.pwrite) apb.prdata = {28'h0, irq_en};
            default:  apb.pslverr = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_apb_dma_fifo.sv
// Self-checking bench: queue-based behavioural model compared every cycle,
// plus directed literal checks and a randomized traffic phase.
module tb_i2s_apb_dma_fifo;
   localparam int D = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   i2s_apb_dma_fifo_if bus();
   logic [31:0] pb_data, cap_data;
   logic pb_read, pb_empty, cap_write, cap_full;
   logic pb_dma_single, pb_dma_req, pb_dma_ack;
   logic cap_dma_single, cap_dma_req, cap_dma_ack, irq;

   i2s_apb_dma_fifo #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .reset_n(reset_n), .apb(bus),
      .pb_data(pb_data), .pb_read(pb_read), .pb_empty(pb_empty),
      .cap_data(cap_data), .cap_write(cap_write), .cap_full(cap_full),
      .pb_dma_single(pb_dma_single), .pb_dma_req(pb_dma_req), .pb_dma_ack(pb_dma_ack),
      .cap_dma_single(cap_dma_single), .cap_dma_req(cap_dma_req), .cap_dma_ack(cap_dma_ack),
      .irq(irq)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Behavioural model state
   logic [31:0] pb_q[$];
   logic [31:0] cap_q[$];
   bit       m_pb_en, m_cap_en, m_under, m_over;
   int       m_pb_wm, m_cap_wm;
   bit [3:0] m_irq_en;
   bit       m_pbs, m_pbr, m_cs, m_cr;

   function automatic bit [3:0] m_flags();
      bit [3:0] f;
      f[0] = m_under;
      f[1] = m_over;
      f[2] = (pb_q.size() <= m_pb_wm);
      f[3] = (m_cap_wm != 0) && (cap_q.size() >= m_cap_wm);
      return f;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [4:0] a, input bit w);
      logic [31:0] s;
      s = 32'h0;
      if (w) return s;
      case (a)
         5'h00: if (cap_q.size() > 0) s = cap_q[0];
         5'h04: begin
            s[0] = (pb_q.size() == 0);
            s[1] = (pb_q.size() == D);
            s[2] = m_pb_en;
            s[3] = (cap_q.size() == 0);
            s[4] = (cap_q.size() == D);
            s[5] = m_cap_en;
            s[15:8]  = 8'(pb_q.size());
            s[31:24] = 8'(cap_q.size());
         end
         5'h08: begin s[1] = m_pb_en; s[3] = m_cap_en; end
         5'h0C: begin s[7:0] = 8'(m_pb_wm); s[23:16] = 8'(m_cap_wm); end
         5'h10: s[3:0] = m_flags();
         5'h14: s[3:0] = m_irq_en;
         default: s = 32'h0;
      endcase
      return s;
   endfunction

   function automatic bit m_err(input logic [4:0] a, input bit w, input bit pbr);
      case (a)
         5'h00: return w ? ((pb_q.size() == D) && !pbr) : (cap_q.size() == 0);
         5'h04, 5'h08, 5'h0C, 5'h10, 5'h14: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // Model update at each active edge
   bit acc, mwr, mrd, pbpop, pbpush, cpop, cpush;
   int pbn, capn;
   logic [4:0]  ma;
   logic [31:0] md;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pb_q.delete(); cap_q.delete();
         m_pb_en = 0; m_cap_en = 0; m_under = 0; m_over = 0;
         m_pb_wm = D / 2; m_cap_wm = D / 2; m_irq_en = 0;
         m_pbs = 0; m_pbr = 0; m_cs = 0; m_cr = 0;
      end else begin
         acc = bus.psel && bus.penable;
         mwr = acc && bus.pwrite;
         mrd = acc && !bus.pwrite;
         ma = bus.paddr; md = bus.pwdata;
         pbn = pb_q.size(); capn = cap_q.size();
         if (pb_dma_ack) begin m_pbs = 0; m_pbr = 0; end
         else begin
            m_pbs = m_pb_en && (pbn < D);
            m_pbr = m_pb_en && (m_pb_wm != 0) && ((D - pbn) >= m_pb_wm);
         end
         if (cap_dma_ack) begin m_cs = 0; m_cr = 0; end
         else begin
            m_cs = m_cap_en && (capn > 0);
            m_cr = m_cap_en && (m_cap_wm != 0) && (capn >= m_cap_wm);
         end
         pbpop  = pb_read && pbn > 0;
         pbpush = mwr && ma == 5'h00 && (pbn < D || pbpop);
         cpop   = mrd && ma == 5'h00 && capn > 0;
         cpush  = cap_write && (capn < D || cpop);
         if (mwr && ma == 5'h10) begin
            if (md[0]) m_under = 0;
            if (md[1]) m_over = 0;
         end
         if (pb_read && pbn == 0) m_under = 1;
         if (cap_write && capn == D && !cpop) m_over = 1;
         if (pbpop)  void'(pb_q.pop_front());
         if (pbpush) pb_q.push_back(md);
         if (cpop)   void'(cap_q.pop_front());
         if (cpush)  cap_q.push_back(cap_data);
         if (mwr && ma == 5'h08) begin
            if (md[0]) pb_q.delete();
            if (md[2]) cap_q.delete();
            m_pb_en = md[1]; m_cap_en = md[3];
         end
         if (mwr && ma == 5'h0C) begin m_pb_wm = int'(md[7:0]); m_cap_wm = int'(md[23:16]); end
         if (mwr && ma == 5'h14) m_irq_en = md[3:0];
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (reset_n) begin
         chk("pb_empty", 32'(pb_empty), 32'(pb_q.size() == 0));
         chk("pb_data", pb_data, (pb_q.size() > 0) ? pb_q[0] : 32'h0);
         chk("cap_full", 32'(cap_full), 32'(cap_q.size() == D));
         chk("irq", 32'(irq), 32'(|(m_flags() & m_irq_en)));
         chk("pb_dma_single", 32'(pb_dma_single), 32'(m_pbs));
         chk("pb_dma_req", 32'(pb_dma_req), 32'(m_pbr));
         chk("cap_dma_single", 32'(cap_dma_single), 32'(m_cs));
         chk("cap_dma_req", 32'(cap_dma_req), 32'(m_cr));
         chk("pready", 32'(bus.pready), 32'(bus.psel && bus.penable));
         if (bus.psel && bus.penable) begin
            chk("prdata", bus.prdata, m_rdata(bus.paddr, bus.pwrite));
            chk("pslverr", 32'(bus.pslverr), 32'(m_err(bus.paddr, bus.pwrite, pb_read)));
         end
      end
   end

   // APB transfer with optional strobes during the access phase; call at posedge+1
   task automatic apb(input bit w, input logic [4:0] a, input logic [31:0] d,
                      input bit pbr, input bit capw, input logic [31:0] cd,
                      output logic [31:0] rdata, output logic err);
      bus.psel = 1; bus.penable = 0; bus.pwrite = w; bus.paddr = a; bus.pwdata = d;
      @(posedge clk); #1;
      bus.penable = 1; pb_read = pbr; cap_write = capw; cap_data = cd;
      @(negedge clk);
      rdata = bus.prdata; err = bus.pslverr;
      @(posedge clk); #1;
      bus.psel = 0; bus.penable = 0; pb_read = 0; cap_write = 0;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d, output logic err);
      logic [31:0] r;
      apb(1'b1, a, d, 1'b0, 1'b0, 32'h0, r, err);
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] r, output logic err);
      apb(1'b0, a, 32'h0, 1'b0, 1'b0, 32'h0, r, err);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] r, d;
      logic e, w, pbr, capw;
      logic [4:0] a;
      int sel, prd;

      bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
      pb_read = 0; cap_write = 0; cap_data = 0; pb_dma_ack = 0; cap_dma_ack = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) reset_n = 1;
      step();

      rd(5'h0C, r, e); chk("thresh_reset", r, 32'h0008_0008);
      rd(5'h04, r, e); chk("status_reset", r, 32'h0000_0009);

      // Playback fill and drain
      for (int i = 0; i < 16; i++) begin
         wr(5'h00, 32'h100 + 32'(i), e); chk("fill_err", 32'(e), 32'h0);
      end
      rd(5'h04, r, e); chk("status_full", r, 32'h0000_100A);
      wr(5'h00, 32'hDEAD, e); chk("overflow_err", 32'(e), 32'h1);
      rd(5'h04, r, e); chk("status_after_ovf", r, 32'h0000_100A);
      for (int i = 0; i < 16; i++) begin
         chk("drain_data", pb_data, 32'h100 + 32'(i));
         pb_read = 1; step(); pb_read = 0;
      end
      chk("drain_empty", 32'(pb_empty), 32'h1);

      // Capture overrun
      wr(5'h14, 32'h2, e);
      for (int i = 1; i <= 17; i++) begin
         cap_write = 1; cap_data = 32'(i); step(); cap_write = 0;
      end
      chk("ovr_irq", 32'(irq), 32'h1);
      rd(5'h10, r, e); chk("flags_ovr", r, 32'hE);
      wr(5'h10, 32'h2, e); chk("irq_w1c", 32'(irq), 32'h0);
      for (int i = 1; i <= 16; i++) begin
         rd(5'h00, r, e); chk("cap_data", r, 32'(i)); chk("cap_err", 32'(e), 32'h0);
      end
      rd(5'h00, r, e); chk("cap_empty_data", r, 32'h0); chk("cap_empty_err", 32'(e), 32'h1);

      // Playback DMA handshake
      wr(5'h0C, 32'h0008_0008, e);
      wr(5'h08, 32'h2, e);
      step();
      chk("dma_req_on", 32'(pb_dma_req), 32'h1); chk("dma_single_on", 32'(pb_dma_single), 32'h1);
      pb_dma_ack = 1; step(); pb_dma_ack = 0;
      chk("dma_req_ack", 32'(pb_dma_req), 32'h0); chk("dma_single_ack", 32'(pb_dma_single), 32'h0);
      step();
      chk("dma_req_back", 32'(pb_dma_req), 32'h1);
      for (int i = 0; i < 9; i++) wr(5'h00, 32'h200 + 32'(i), e);
      step();
      chk("dma_req_free7", 32'(pb_dma_req), 32'h0); chk("dma_single_free7", 32'(pb_dma_single), 32'h1);

      // Simultaneous push/pop
      for (int i = 0; i < 7; i++) wr(5'h00, 32'h300 + 32'(i), e);
      apb(1'b1, 5'h00, 32'h55, 1'b1, 1'b0, 32'h0, r, e); chk("full_pushpop_err", 32'(e), 32'h0);
      rd(5'h04, r, e); chk("full_pushpop_cnt", 32'(r[15:8]), 32'd16);
      wr(5'h08, 32'h3, e);
      apb(1'b1, 5'h00, 32'h77, 1'b1, 1'b0, 32'h0, r, e);
      rd(5'h10, r, e); chk("underrun_flag", 32'(r[0]), 32'h1);
      rd(5'h04, r, e); chk("empty_pushpop_cnt", 32'(r[15:8]), 32'd1);

      // Clear priority
      for (int i = 0; i < 3; i++) begin cap_write = 1; cap_data = 32'h400 + 32'(i); step(); cap_write = 0; end
      apb(1'b1, 5'h08, 32'h5, 1'b0, 1'b1, 32'h99, r, e);
      rd(5'h04, r, e); chk("clr_pb_cnt", 32'(r[15:8]), 32'd0); chk("clr_cap_cnt", 32'(r[31:24]), 32'd0);
      rd(5'h08, r, e); chk("ctrl_readback", r, 32'h0);

      // Randomized traffic
      for (int it = 0; it < 2500; it++) begin
         prd = (it < 1250) ? 8 : 2;
         pb_dma_ack  = ($urandom_range(0, 5) == 0);
         cap_dma_ack = ($urandom_range(0, 5) == 0);
         pbr  = ($urandom_range(0, prd - 1) == 0);
         capw = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 1) == 1) begin
            sel = $urandom_range(0, 11);
            case (sel)
               0, 1, 2, 3, 4: a = 5'h00;
               5: a = 5'h04;
               6: a = 5'h08;
               7: a = 5'h0C;
               8: a = 5'h10;
               9: a = 5'h14;
               10: a = 5'h18;
               default: a = 5'h03;
            endcase
            w = $urandom_range(0, 1);
            d = $urandom;
            if (a == 5'h08 && $urandom_range(0, 7) != 0) begin d[0] = 0; d[2] = 0; end
            if (a == 5'h0C) d = (32'($urandom_range(0, 20)) << 16) | 32'($urandom_range(0, 20));
            apb(w, a, d, pbr, capw, $urandom, r, e);
         end else begin
            pb_read = pbr; cap_write = capw; cap_data = $urandom;
            step();
            pb_read = 0; cap_write = 0;
         end
      end
      pb_dma_ack = 0; cap_dma_ack = 0;

      // Asynchronous reset in the middle of an access
      wr(5'h08, 32'hA, e);
      wr(5'h14, 32'hF, e);
      wr(5'h00, 32'h1, e);
      bus.psel = 1; bus.pwrite = 1; bus.paddr = 5'h00; bus.pwdata = 32'h5;
      step();
      bus.penable = 1; pb_read = 1;
      #2 reset_n = 0;
      #1;
      chk("rst_pready", 32'(bus.pready), 32'h0);
      chk("rst_prdata", bus.prdata, 32'h0);
      chk("rst_pslverr", 32'(bus.pslverr), 32'h0);
      chk("rst_pb_data", pb_data, 32'h0);
      chk("rst_pb_empty", 32'(pb_empty), 32'h1);
      chk("rst_cap_full", 32'(cap_full), 32'h0);
      chk("rst_dma", {28'h0, pb_dma_single, pb_dma_req, cap_dma_single, cap_dma_req}, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      bus.psel = 0; bus.penable = 0; pb_read = 0;
      @(negedge clk) reset_n = 1;
      step();
      rd(5'h0C, r, e); chk("thresh_after_rst", r, 32'h0008_0008);
      rd(5'h04, r, e); chk("status_after_rst", r, 32'h0000_0009);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
